// File: rtl/quad_encoder_pkg.sv
// Register map, count-mode encoding and CTRL/STATUS bit positions shared by quad_encoder_multi.
package quad_encoder_pkg;

  localparam logic [1:0] REG_COUNT  = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_LATCH  = 2'd3;

  typedef enum logic [1:0] {
    MODE_X4     = 2'd0,
    MODE_X2     = 2'd1,
    MODE_X1     = 2'd2,
    MODE_X4_ALT = 2'd3
  } mode_e;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_INV  = 3;
  localparam int CTRL_FILT = 4;

  localparam int STAT_OVF = 0;
  localparam int STAT_UNF = 1;
  localparam int STAT_ERR = 2;
  localparam int STAT_IDX = 3;

  // Decides whether a valid Gray step is counted under the selected resolution.
  function automatic logic mode_counts(input mode_e mode, input logic a_chg, input logic a_now);
    case (mode)
      MODE_X2: return a_chg;
      MODE_X1: return a_chg & a_now;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/quad_encoder_channel.sv
// One encoder channel: 2-flop sync, glitch filter, Gray decode, counter, CTRL/STATUS/LATCH.
// Index capture/clear is built only when QUAD_ENCODER_INDEX_EN is defined.
module quad_encoder_channel
  import quad_encoder_pkg::*;
#(
  parameter int pPRECISION   = 32,
  parameter int pFILTER_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        enc_i,
  input  logic        ctrl_wr,
  input  logic        count_wr,
  input  logic        status_wr,
  input  logic [31:0] wdata,
  output logic [31:0] count_rd,
  output logic [31:0] ctrl_rd,
  output logic [31:0] status_rd,
  output logic [31:0] latch_rd
);

`ifdef QUAD_ENCODER_INDEX_EN
  localparam int NSIG = 3;
`else
  localparam int NSIG = 2;
`endif
  localparam logic [pPRECISION-1:0] ALL_ONES = '1;

  logic [NSIG-1:0]         pins;
  logic [NSIG-1:0]         sync1;
  logic [NSIG-1:0]         sync2;
  logic [NSIG-1:0]         filt;
  logic [NSIG-1:0]         prev;
  logic [pFILTER_BITS-1:0] fcnt [NSIG];

  logic                    en;
  logic                    inv;
  mode_e                   mode;
  logic [pFILTER_BITS-1:0] filt_len;
  logic [pPRECISION-1:0]   count;
  logic [3:0]              status;
  logic [3:0]              set_flags;

  logic a_chg, b_chg, gray_step, both_chg, step_up, step_cnt;
  logic idx_rise, idx_zero, wrap_up, wrap_dn;
  logic unused_ok;

`ifdef QUAD_ENCODER_INDEX_EN
  logic                  idx_clr;
  logic [pPRECISION-1:0] latch;
  assign pins      = {enc_i, enc_b, enc_a};
  assign idx_rise  = filt[2] & ~prev[2];
  assign idx_zero  = idx_rise & idx_clr & en;
  assign unused_ok = ^wdata;
`else
  assign pins      = {enc_b, enc_a};
  assign idx_rise  = 1'b0;
  assign idx_zero  = 1'b0;
  assign unused_ok = ^{wdata, enc_i};
`endif

  // Filter output follows the synced pin only after FILT+1 consecutive cycles of disagreement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      prev  <= '0;
      for (int k = 0; k < NSIG; k++) fcnt[k] <= '0;
    end else begin
      sync1 <= pins;
      sync2 <= sync1;
      prev  <= filt;
      for (int k = 0; k < NSIG; k++) begin
        if (sync2[k] == filt[k]) begin
          fcnt[k] <= '0;
        end else if (fcnt[k] == filt_len) begin
          filt[k] <= sync2[k];
          fcnt[k] <= '0;
        end else begin
          fcnt[k] <= fcnt[k] + pFILTER_BITS'(1);
        end
      end
    end
  end

  assign a_chg     = filt[0] ^ prev[0];
  assign b_chg     = filt[1] ^ prev[1];
  assign gray_step = a_chg ^ b_chg;
  assign both_chg  = a_chg & b_chg;
  assign step_up   = (filt[0] ^ prev[1]) ^ inv;
  assign step_cnt  = en & gray_step & mode_counts(mode, a_chg, filt[0]);
  assign wrap_up   = step_cnt & step_up & (count == ALL_ONES) & ~count_wr & ~idx_zero;
  assign wrap_dn   = step_cnt & ~step_up & (count == '0) & ~count_wr & ~idx_zero;

  always_comb begin
    set_flags           = '0;
    set_flags[STAT_OVF] = wrap_up;
    set_flags[STAT_UNF] = wrap_dn;
    set_flags[STAT_ERR] = en & both_chg;
    set_flags[STAT_IDX] = idx_rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en       <= 1'b1;
      mode     <= MODE_X4;
      inv      <= 1'b0;
      filt_len <= '0;
    end else if (ctrl_wr) begin
      en       <= wdata[CTRL_EN];
      mode     <= mode_e'(wdata[CTRL_MODE +: 2]);
      inv      <= wdata[CTRL_INV];
      filt_len <= wdata[CTRL_FILT +: pFILTER_BITS];
    end
  end

  // Priority: bus preset, then index clear, then the decoded step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (count_wr) begin
      count <= wdata[pPRECISION-1:0];
    end else if (idx_zero) begin
      count <= '0;
    end else if (step_cnt) begin
      count <= step_up ? count + pPRECISION'(1) : count - pPRECISION'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status <= '0;
    end else begin
      status <= (status_wr ? (status & ~wdata[3:0]) : status) | set_flags;
    end
  end

`ifdef QUAD_ENCODER_INDEX_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_clr <= 1'b0;
      latch   <= '0;
    end else begin
      if (ctrl_wr) idx_clr <= wdata[CTRL_FILT + pFILTER_BITS];
      if (idx_rise) latch <= count;
    end
  end
  assign latch_rd = 32'(latch);
`else
  assign latch_rd = '0;
`endif

  always_comb begin
    ctrl_rd                               = '0;
    ctrl_rd[CTRL_EN]                      = en;
    ctrl_rd[CTRL_MODE +: 2]               = mode;
    ctrl_rd[CTRL_INV]                     = inv;
    ctrl_rd[CTRL_FILT +: pFILTER_BITS]    = filt_len;
`ifdef QUAD_ENCODER_INDEX_EN
    ctrl_rd[CTRL_FILT + pFILTER_BITS]     = idx_clr;
`endif
  end

  assign count_rd  = 32'(count);
  assign status_rd = {28'd0, status};

endmodule

// File: rtl/quad_encoder_multi.sv
// Multi-channel quadrature decoder behind an Avalon-MM slave; address = {channel, reg[1:0]}.
// Read data is registered one cycle after iAVL_READ; index support via QUAD_ENCODER_INDEX_EN.
module quad_encoder_multi
  import quad_encoder_pkg::*;
#(
  parameter int pENCODERS          = 4,
  parameter int pENCODER_PRECISION = 32,
  parameter int pFILTER_BITS       = 4
) (
  input  logic                             iCLK,
  input  logic                             iRESET,
  input  logic [$clog2(pENCODERS)+1:0]     iAVL_ADDRESS,
  input  logic                             iAVL_READ,
  input  logic                             iAVL_WRITE,
  input  logic [31:0]                      iAVL_WRITE_DATA,
  output logic [31:0]                      oAVL_READ_DATA,
  input  logic [pENCODERS-1:0]             iENCODER_A,
  input  logic [pENCODERS-1:0]             iENCODER_B,
  input  logic [pENCODERS-1:0]             iENCODER_I
);

  localparam int CHW = (pENCODERS > 1) ? $clog2(pENCODERS) : 1;

  logic [CHW-1:0] ch;
  logic [1:0]     reg_sel;
  logic [31:0]    rd_mux;
  logic [31:0]    count_rd  [pENCODERS];
  logic [31:0]    ctrl_rd   [pENCODERS];
  logic [31:0]    status_rd [pENCODERS];
  logic [31:0]    latch_rd  [pENCODERS];

  assign reg_sel = iAVL_ADDRESS[1:0];
  // Channel numbers without a matching instance select nothing: reads give 0, writes drop.
  assign ch      = CHW'(iAVL_ADDRESS >> 2);

  for (genvar g = 0; g < pENCODERS; g++) begin : g_ch
    logic sel;
    assign sel = (ch == CHW'(g));

    quad_encoder_channel #(
      .pPRECISION   (pENCODER_PRECISION),
      .pFILTER_BITS (pFILTER_BITS)
    ) u_channel (
      .clk       (iCLK),
      .rst       (iRESET),
      .enc_a     (iENCODER_A[g]),
      .enc_b     (iENCODER_B[g]),
      .enc_i     (iENCODER_I[g]),
      .ctrl_wr   (iAVL_WRITE && sel && (reg_sel == REG_CTRL)),
      .count_wr  (iAVL_WRITE && sel && (reg_sel == REG_COUNT)),
      .status_wr (iAVL_WRITE && sel && (reg_sel == REG_STATUS)),
      .wdata     (iAVL_WRITE_DATA),
      .count_rd  (count_rd[g]),
      .ctrl_rd   (ctrl_rd[g]),
      .status_rd (status_rd[g]),
      .latch_rd  (latch_rd[g])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < pENCODERS; c++) begin
      if (ch == CHW'(c)) begin
        case (reg_sel)
          REG_COUNT:  rd_mux = count_rd[c];
          REG_CTRL:   rd_mux = ctrl_rd[c];
          REG_STATUS: rd_mux = status_rd[c];
          default:    rd_mux = latch_rd[c];
        endcase
      end
    end
  end

  // Sampling the mux before the edge makes a simultaneous read return the pre-write value.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      oAVL_READ_DATA <= '0;
    end else if (iAVL_READ) begin
      oAVL_READ_DATA <= rd_mux;
    end
  end

endmodule

// File: tb/tb_quad_encoder_multi.sv
// Scoreboard bench for quad_encoder_multi: 3 channels, 8-bit counters, 4-bit filter field.
module tb_quad_encoder_multi;
  import quad_encoder_pkg::*;

  localparam int NCH = 3;
  localparam int P   = 8;
  localparam int FB  = 4;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic          rd;
  logic          wr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic [NCH-1:0] enc_a;
  logic [NCH-1:0] enc_b;
  logic [NCH-1:0] enc_i;

  int errors = 0;
  int checks = 0;

  string       name_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  always #5 clk = ~clk;

  quad_encoder_multi #(
    .pENCODERS          (NCH),
    .pENCODER_PRECISION (P),
    .pFILTER_BITS       (FB)
  ) dut (
    .iCLK            (clk),
    .iRESET          (rst),
    .iAVL_ADDRESS    (addr),
    .iAVL_READ       (rd),
    .iAVL_WRITE      (wr),
    .iAVL_WRITE_DATA (wdata),
    .oAVL_READ_DATA  (rdata),
    .iENCODER_A      (enc_a),
    .iENCODER_B      (enc_b),
    .iENCODER_I      (enc_i)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input int ch, input logic [1:0] r, input logic [31:0] d);
    addr = {2'(ch), r};
    wr = 1'b1;
    wdata = d;
    tick(1);
    wr = 1'b0;
  endtask

  task automatic sample(input int ch, input logic [1:0] r);
    addr = {2'(ch), r};
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    got_q.push_back(rdata);
  endtask

  task automatic expect_val(input string n, input logic [31:0] v);
    name_q.push_back(n);
    exp_q.push_back(v);
  endtask

  task automatic drive_step(input int ch, input bit up);
    logic a, b;
    a = enc_a[ch];
    b = enc_b[ch];
    if (up) begin
      enc_a[ch] = ~b;
      enc_b[ch] = a;
    end else begin
      enc_a[ch] = b;
      enc_b[ch] = ~a;
    end
  endtask

  task automatic step(input int ch, input bit up, input int n);
    repeat (n) begin
      drive_step(ch, up);
      tick(2);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    for (int c = 0; c < NCH; c++) begin
      expect_val($sformatf("rst_count_c%0d", c), 32'h0);   sample(c, REG_COUNT);
      expect_val($sformatf("rst_ctrl_c%0d", c), 32'h1);    sample(c, REG_CTRL);
      expect_val($sformatf("rst_status_c%0d", c), 32'h0);  sample(c, REG_STATUS);
      expect_val($sformatf("rst_latch_c%0d", c), 32'h0);   sample(c, REG_LATCH);
    end
    bus_write(3, REG_CTRL, 32'h5);
    expect_val("bad_chan_ctrl", 32'h0);   sample(3, REG_CTRL);
    expect_val("bad_chan_count", 32'h0);  sample(3, REG_COUNT);
    while (exp_q.size() > 0) begin
      string n; logic [31:0] e, g;
      n = name_q.pop_front(); e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got 0x%h, expected 0x%h", n, g, e); end
    end
  endtask

  task automatic test_x4;
    addr = {2'd0, REG_COUNT};
    rd = 1'b1;
    drive_step(0, 1'b1);
    expect_val("lat_f0_before", 32'h0);
    tick(4);
    got_q.push_back(rdata);
    expect_val("lat_f0_after", 32'h1);
    tick(1);
    got_q.push_back(rdata);
    rd = 1'b0;
    step(0, 1'b1, 7);
    tick(8);
    expect_val("x4_up8", 32'd8);     sample(0, REG_COUNT);
    step(0, 1'b0, 3);
    tick(8);
    expect_val("x4_down3", 32'd5);   sample(0, REG_COUNT);
    expect_val("x4_status", 32'h0);  sample(0, REG_STATUS);
    while (exp_q.size() > 0) begin
      string n; logic [31:0] e, g;
      n = name_q.pop_front(); e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got 0x%h, expected 0x%h", n, g, e); end
    end
  endtask

  task automatic test_modes;
    bus_write(1, REG_CTRL, 32'h5);
    step(1, 1'b1, 16);
    tick(8);
    expect_val("x1_count", 32'd4);     sample(1, REG_COUNT);
    bus_write(1, REG_COUNT, 32'h0);
    bus_write(1, REG_CTRL, 32'h3);
    step(1, 1'b1, 16);
    tick(8);
    expect_val("x2_count", 32'd8);     sample(1, REG_COUNT);
    bus_write(1, REG_COUNT, 32'h0);
    bus_write(1, REG_CTRL, 32'h9);
    step(1, 1'b1, 16);
    tick(8);
    expect_val("inv_count", 32'hF0);   sample(1, REG_COUNT);
    expect_val("inv_ctrl", 32'h9);     sample(1, REG_CTRL);
    expect_val("inv_unf", 32'h2);      sample(1, REG_STATUS);
    while (exp_q.size() > 0) begin
      string n; logic [31:0] e, g;
      n = name_q.pop_front(); e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got 0x%h, expected 0x%h", n, g, e); end
    end
  endtask

  task automatic test_wrap;
    bus_write(2, REG_COUNT, 32'h1234);
    expect_val("preset_trunc", 32'h34);  sample(2, REG_COUNT);
    bus_write(2, REG_COUNT, 32'hFF);
    step(2, 1'b1, 1);
    tick(8);
    expect_val("ovf_count", 32'h0);      sample(2, REG_COUNT);
    expect_val("ovf_flag", 32'h1);       sample(2, REG_STATUS);
    bus_write(2, REG_STATUS, 32'h1);
    expect_val("w1c_clear", 32'h0);      sample(2, REG_STATUS);
    step(2, 1'b0, 1);
    tick(8);
    expect_val("unf_count", 32'hFF);     sample(2, REG_COUNT);
    expect_val("unf_flag", 32'h2);       sample(2, REG_STATUS);
    while (exp_q.size() > 0) begin
      string n; logic [31:0] e, g;
      n = name_q.pop_front(); e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got 0x%h, expected 0x%h", n, g, e); end
    end
  endtask

  task automatic test_filter;
    bus_write(0, REG_CTRL, 32'h31);
    bus_write(0, REG_COUNT, 32'h0);
    enc_a[0] = ~enc_a[0];
    tick(2);
    enc_a[0] = ~enc_a[0];
    tick(10);
    expect_val("glitch_rejected", 32'h0);  sample(0, REG_COUNT);
    addr = {2'd0, REG_COUNT};
    rd = 1'b1;
    drive_step(0, 1'b1);
    expect_val("filt3_before", 32'h0);
    tick(7);
    got_q.push_back(rdata);
    expect_val("filt3_after", 32'h1);
    tick(1);
    got_q.push_back(rdata);
    rd = 1'b0;
    tick(4);
    enc_a[0] = ~enc_a[0];
    enc_b[0] = ~enc_b[0];
    tick(12);
    expect_val("err_count", 32'h1);   sample(0, REG_COUNT);
    expect_val("err_flag", 32'h4);    sample(0, REG_STATUS);
    while (exp_q.size() > 0) begin
      string n; logic [31:0] e, g;
      n = name_q.pop_front(); e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got 0x%h, expected 0x%h", n, g, e); end
    end
  endtask

  task automatic test_collision;
    bus_write(0, REG_CTRL, 32'h1);
    bus_write(0, REG_STATUS, 32'hF);
    tick(4);
    drive_step(0, 1'b1);
    tick(3);
    addr = {2'd0, REG_COUNT};
    wdata = 32'h55;
    wr = 1'b1;
    tick(1);
    wr = 1'b0;
    expect_val("write_beats_step", 32'h55);  sample(0, REG_COUNT);
    tick(6);
    expect_val("step_not_deferred", 32'h55); sample(0, REG_COUNT);
    bus_write(0, REG_CTRL, 32'h0);
    step(0, 1'b1, 10);
    tick(8);
    expect_val("disabled_frozen", 32'h55);   sample(0, REG_COUNT);
    bus_write(0, REG_CTRL, 32'h1);
    tick(8);
    expect_val("reenable_no_burst", 32'h55); sample(0, REG_COUNT);
    step(0, 1'b1, 1);
    tick(8);
    expect_val("reenable_counts", 32'h56);   sample(0, REG_COUNT);
    addr = {2'd0, REG_COUNT};
    wdata = 32'h77;
    rd = 1'b1;
    wr = 1'b1;
    tick(1);
    rd = 1'b0;
    wr = 1'b0;
    expect_val("rw_same_cycle_old", 32'h56);
    got_q.push_back(rdata);
    expect_val("rw_same_cycle_new", 32'h77); sample(0, REG_COUNT);
    while (exp_q.size() > 0) begin
      string n; logic [31:0] e, g;
      n = name_q.pop_front(); e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got 0x%h, expected 0x%h", n, g, e); end
    end
  endtask

  task automatic test_index;
    logic [31:0] latch1, status1, ctrl2, count2, latch2;
`ifdef QUAD_ENCODER_INDEX_EN
    latch1 = 32'd100; status1 = 32'h8; ctrl2 = 32'h101; count2 = 32'd0;   latch2 = 32'd100;
`else
    latch1 = 32'd0;   status1 = 32'h0; ctrl2 = 32'h001; count2 = 32'd100; latch2 = 32'd0;
`endif
    bus_write(1, REG_CTRL, 32'h1);
    bus_write(1, REG_STATUS, 32'hF);
    bus_write(1, REG_COUNT, 32'd100);
    enc_i[1] = 1'b1;
    tick(10);
    expect_val("idx_latch", latch1);     sample(1, REG_LATCH);
    expect_val("idx_status", status1);   sample(1, REG_STATUS);
    expect_val("idx_count_kept", 32'd100); sample(1, REG_COUNT);
    enc_i[1] = 1'b0;
    tick(10);
    bus_write(1, REG_CTRL, 32'h101);
    expect_val("idxclr_ctrl", ctrl2);    sample(1, REG_CTRL);
    enc_i[1] = 1'b1;
    tick(10);
    expect_val("idxclr_count", count2);  sample(1, REG_COUNT);
    expect_val("idxclr_latch", latch2);  sample(1, REG_LATCH);
    enc_i[1] = 1'b0;
    tick(10);
    while (exp_q.size() > 0) begin
      string n; logic [31:0] e, g;
      n = name_q.pop_front(); e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got 0x%h, expected 0x%h", n, g, e); end
    end
  endtask

  task automatic test_reset_mid;
    step(0, 1'b1, 3);
    drive_step(0, 1'b1);
    #3 rst = 1'b1;
    #4 rst = 1'b0;
    tick(1);
    expect_val("mid_rst_rdata", 32'h0);
    got_q.push_back(rdata);
    tick(8);
    for (int c = 0; c < NCH; c++) begin
      expect_val($sformatf("mid_rst_count_c%0d", c), 32'h0);  sample(c, REG_COUNT);
      expect_val($sformatf("mid_rst_ctrl_c%0d", c), 32'h1);   sample(c, REG_CTRL);
      expect_val($sformatf("mid_rst_status_c%0d", c), 32'h0); sample(c, REG_STATUS);
      expect_val($sformatf("mid_rst_latch_c%0d", c), 32'h0);  sample(c, REG_LATCH);
    end
    while (exp_q.size() > 0) begin
      string n; logic [31:0] e, g;
      n = name_q.pop_front(); e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got 0x%h, expected 0x%h", n, g, e); end
    end
  endtask

  initial begin
    rst   = 1'b1;
    addr  = '0;
    rd    = 1'b0;
    wr    = 1'b0;
    wdata = '0;
    enc_a = '0;
    enc_b = '0;
    enc_i = '0;
    test_reset;
    test_x4;
    test_modes;
    test_wrap;
    test_filter;
    test_collision;
    test_index;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
